// File: rtl/multicycle_alu.sv
// Execute-stage ALU: registered single-cycle ops, iterative signed MULT/DIV into HI/LO.
// Optional signed-overflow detection for ADD/SUB is built when ALU_OVF_DETECT_EN is defined.
module multicycle_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_operation,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   localparam int ITER = WIDTH;
   localparam int SHW  = $clog2(WIDTH);
   localparam int CW   = $clog2(ITER);

   localparam logic [3:0] OP_XOR  = 4'd1;
   localparam logic [3:0] OP_OR   = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_NOR  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SRL  = 4'd6;
   localparam logic [3:0] OP_SLT  = 4'd7;
   localparam logic [3:0] OP_ADD  = 4'd8;
   localparam logic [3:0] OP_ADDU = 4'd9;
   localparam logic [3:0] OP_SUB  = 4'd10;
   localparam logic [3:0] OP_SUBU = 4'd11;
   localparam logic [3:0] OP_MULT = 4'd12;
   localparam logic [3:0] OP_DIV  = 4'd13;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] result_q, hi_q, lo_q;
   logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
   logic             zero_q, busy_q, done_q;
   logic             sign_a_q, sign_b_q, is_div_q;
   logic [CW-1:0]    cnt_q;

   logic [WIDTH-1:0]   result_d;
   logic               zero_d;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic               is_muldiv;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ge;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] prod;

   assign abs_a     = a[WIDTH-1] ? -a : a;
   assign abs_b     = b[WIDTH-1] ? -b : b;
   assign is_muldiv = (alu_operation == OP_MULT) || (alu_operation == OP_DIV);

   // acc_hi holds the partial product / remainder, acc_lo the multiplier / dividend-quotient.
   assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
   assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_sub   = div_shift[WIDTH-1:0] - opnd_q;
   assign prod      = {acc_hi_q, acc_lo_q};

   always_comb begin
      result_d = '0;
      case (alu_operation)
         OP_XOR:          result_d = a ^ b;
         OP_OR:           result_d = a | b;
         OP_AND:          result_d = a & b;
         OP_NOR:          result_d = ~(a | b);
         OP_SLL:          result_d = b << a[SHW-1:0];
         OP_SRL:          result_d = b >> a[SHW-1:0];
         OP_SLT:          result_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
         OP_ADD, OP_ADDU: result_d = a + b;
         OP_SUB, OP_SUBU: result_d = a - b;
         default:         result_d = '0;
      endcase
      zero_d = (result_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         is_div_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && is_muldiv) begin
                  is_div_q <= (alu_operation == OP_DIV);
                  acc_hi_q <= '0;
                  acc_lo_q <= (alu_operation == OP_DIV) ? abs_a : abs_b;
                  opnd_q   <= (alu_operation == OP_DIV) ? abs_b : abs_a;
                  sign_a_q <= a[WIDTH-1];
                  sign_b_q <= b[WIDTH-1];
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= (alu_operation == OP_DIV) ? S_DIV : S_MUL;
               end else if (start) begin
                  result_q <= result_d;
                  zero_q   <= zero_d;
                  done_q   <= 1'b1;
               end
            end
            S_MUL: begin
               acc_hi_q <= mul_sum[WIDTH:1];
               acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CW'(ITER - 1)) state_q <= S_FIX;
            end
            S_DIV: begin
               acc_hi_q <= div_ge ? div_sub : div_shift[WIDTH-1:0];
               acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
               cnt_q    <= cnt_q + CW'(1);
               if (cnt_q == CW'(ITER - 1)) state_q <= S_FIX;
            end
            S_FIX: begin
               if (is_div_q) begin
                  // Divide by zero must report all-ones quotient regardless of operand signs.
                  lo_q <= (opnd_q == '0) ? '1 : ((sign_a_q ^ sign_b_q) ? -acc_lo_q : acc_lo_q);
                  hi_q <= sign_a_q ? -acc_hi_q : acc_hi_q;
               end else begin
                  {hi_q, lo_q} <= (sign_a_q ^ sign_b_q) ? -prod : prod;
               end
               cnt_q   <= '0;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef ALU_OVF_DETECT_EN
   logic ovf_d, ovf_q;

   always_comb begin
      ovf_d = 1'b0;
      case (alu_operation)
         OP_ADD:  ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (result_d[WIDTH-1] != a[WIDTH-1]);
         OP_SUB:  ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (result_d[WIDTH-1] != a[WIDTH-1]);
         default: ovf_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state_q == S_IDLE && start && !is_muldiv) begin
         ovf_q <= ovf_d;
      end
   end

   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

   assign result = result_q;
   assign zero   = zero_q;
   assign hi     = hi_q;
   assign lo     = lo_q;
   assign busy   = busy_q;
   assign done   = done_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: expectations queued at issue, compared when done pulses.
module tb_multicycle_alu;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [3:0]   op;
   logic [W-1:0] a, b;
   logic [W-1:0] result, hi, lo;
   logic         zero, overflow, busy, done;

   always #5 clk = ~clk;

   multicycle_alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .alu_operation(op), .a(a), .b(b),
      .result(result), .zero(zero), .overflow(overflow), .hi(hi), .lo(lo),
      .busy(busy), .done(done)
   );

   typedef struct {
      logic [31:0] res;
      logic        z;
      logic        ov;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] cur_res = '0, cur_hi = '0, cur_lo = '0;
   logic        cur_z = 1'b0, cur_ov = 1'b0;

   function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t   e;
      longint sx, sy, s;
      e.res = cur_res; e.z = cur_z; e.ov = cur_ov; e.hi = cur_hi; e.lo = cur_lo;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o == 4'd12) begin
         s = sx * sy;
         e.hi = s[63:32];
         e.lo = s[31:0];
      end else if (o == 4'd13) begin
         if (y == 32'd0) begin
            e.lo = 32'hFFFFFFFF;
            e.hi = x;
         end else begin
            s = sx / sy;
            e.lo = s[31:0];
            s = sx % sy;
            e.hi = s[31:0];
         end
      end else begin
         e.ov = 1'b0;
         case (o)
            4'd1:        e.res = x ^ y;
            4'd2:        e.res = x | y;
            4'd3:        e.res = x & y;
            4'd4:        e.res = ~(x | y);
            4'd5:        e.res = y << x[4:0];
            4'd6:        e.res = y >> x[4:0];
            4'd7:        e.res = (sx < sy) ? 32'd1 : 32'd0;
            4'd8, 4'd9:  e.res = x + y;
            4'd10, 4'd11: e.res = x - y;
            default:     e.res = 32'd0;
         endcase
`ifdef ALU_OVF_DETECT_EN
         if (o == 4'd8 || o == 4'd10) begin
            s = (o == 4'd8) ? sx + sy : sx - sy;
            e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
`endif
         e.z = (e.res == 32'd0);
      end
      return e;
   endfunction

   // Drive one request at the current (negedge) time and queue its expectation.
   task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      exp_t e;
      e = model(o, x, y);
      op = o; a = x; b = y; start = 1'b1;
      sb.push_back(e);
      if (o == 4'd12 || o == 4'd13) begin
         cur_hi = e.hi; cur_lo = e.lo;
      end else begin
         cur_res = e.res; cur_z = e.z; cur_ov = e.ov;
      end
      $display("issue op=%0d a=%h b=%h", o, x, y);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({result, zero, overflow, hi, lo, busy, done} !== '0)
         begin errors++; $display("FAIL reset: got res=%h z=%b ov=%b hi=%h lo=%h busy=%b done=%b want all 0",
                                  result, zero, overflow, hi, lo, busy, done); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_ops();
      logic [3:0]  ops[10] = '{4'd8, 4'd9, 4'd10, 4'd7, 4'd5, 4'd6, 4'd0, 4'd14, 4'd10, 4'd7};
      logic [31:0] as[10]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'd5, 32'hFFFFFFFF, 32'd4, 32'd31,
                               32'h123, 32'h55, 32'h80000000, 32'd1};
      logic [31:0] bs[10]  = '{32'd1, 32'd1, 32'd5, 32'd1, 32'd1, 32'h80000000,
                               32'h456, 32'hAA, 32'd1, 32'hFFFFFFFF};
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         if (i < 10) issue(ops[i], as[i], bs[i]);
         else        issue(4'($urandom_range(0, 11)), $urandom, $urandom);
         @(negedge clk);
         start = 1'b0;
         e = sb.pop_front();
         checks++;
         if ({done, result, zero, overflow, hi, lo} !== {1'b1, e.res, e.z, e.ov, e.hi, e.lo})
            begin errors++; $display("FAIL single[%0d]: got done=%b res=%h z=%b ov=%b hi=%h lo=%h want done=1 res=%h z=%b ov=%b hi=%h lo=%h",
                                     i, done, result, zero, overflow, hi, lo, e.res, e.z, e.ov, e.hi, e.lo); end
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin errors++; $display("FAIL single_pulse[%0d]: done=%b want 0", i, done); end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops[4]  = '{4'd1, 4'd2, 4'd3, 4'd4};
      logic [31:0] want[4] = '{32'h0FF00FF0, 32'hFFF0FFF0, 32'hF000F000, 32'h000F000F};
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], 32'hF0F0F0F0, 32'hFF00FF00);
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (done !== 1'b1 || result !== want[i] || result !== e.res)
            begin errors++; $display("FAIL b2b[%0d]: got done=%b res=%h want done=1 res=%h", i, done, result, want[i]); end
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_muldiv();
      logic [3:0]  ops[9] = '{4'd12, 4'd12, 4'd12, 4'd13, 4'd13, 4'd13, 4'd13, 4'd13, 4'd12};
      logic [31:0] as[9]  = '{32'hFFFFFFFD, 32'h80000000, 32'h0001E240, 32'hFFFFFFF9, 32'd9,
                              32'h80000000, 32'hFFFFFFF9, 32'h0BADF00D, 32'hDEADBEEF};
      logic [31:0] bs[9]  = '{32'd7, 32'h80000000, 32'hFFFF0005, 32'd2, 32'd0,
                              32'hFFFFFFFF, 32'd0, 32'hFFFFF123, 32'hCAFEBABE};
      exp_t e;
      int   k;
      bit   dropped;
      for (int i = 0; i < 9; i++) begin
         issue(ops[i], as[i], bs[i]);
         @(negedge clk);
         start = 1'b0; a = $urandom; b = $urandom;
         checks++;
         if (busy !== 1'b1 || done !== 1'b0)
            begin errors++; $display("FAIL md_busy[%0d]: busy=%b done=%b want busy=1 done=0", i, busy, done); end
         k = 0; dropped = 1'b0;
         while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            a = $urandom; b = $urandom;
            if (done !== 1'b1 && busy !== 1'b1) dropped = 1'b1;
         end
         checks++;
         if (k != 33 || dropped)
            begin errors++; $display("FAIL md_latency[%0d]: done after %0d cycles busy_dropped=%b want 33 cycles", i, k, dropped); end
         e = sb.pop_front();
         checks++;
         if ({busy, result, zero, overflow, hi, lo} !== {1'b0, e.res, e.z, e.ov, e.hi, e.lo})
            begin errors++; $display("FAIL md[%0d]: got busy=%b res=%h z=%b ov=%b hi=%h lo=%h want busy=0 res=%h z=%b ov=%b hi=%h lo=%h",
                                     i, busy, result, zero, overflow, hi, lo, e.res, e.z, e.ov, e.hi, e.lo); end
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin errors++; $display("FAIL md_pulse[%0d]: done=%b want 0", i, done); end
      end
   endtask

   task automatic test_busy_ignore();
      exp_t e;
      int   k, ndone;
      issue(4'd12, 32'h12345678, 32'hFEDCBA98);
      k = 0; ndone = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         a = $urandom; b = $urandom;
         if (done === 1'b1) begin ndone++; break; end
      end
      e = sb.pop_front();
      checks++;
      if (ndone != 1 || k != 34 || hi !== e.hi || lo !== e.lo)
         begin errors++; $display("FAIL busy_ignore: dones=%0d at cycle %0d hi=%h lo=%h want 1 at 34 hi=%h lo=%h",
                                  ndone, k, hi, lo, e.hi, e.lo); end
      issue(4'd8, 32'd7, 32'd9);
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || result !== e.res)
         begin errors++; $display("FAIL start_after_done: done=%b busy=%b res=%h want done=1 busy=0 res=%h",
                                  done, busy, result, e.res); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL after_done_idle: done=%b busy=%b want 0 0", done, busy); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      int   seen;
      issue(4'd12, 32'hFFFFFFFD, 32'd7);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({result, zero, overflow, hi, lo, busy, done} !== '0)
         begin errors++; $display("FAIL reset_mid: got res=%h z=%b ov=%b hi=%h lo=%h busy=%b done=%b want all 0",
                                  result, zero, overflow, hi, lo, busy, done); end
      sb.delete();
      cur_res = '0; cur_z = 1'b0; cur_ov = 1'b0; cur_hi = '0; cur_lo = '0;
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL reset_abort: %0d cycles with done/busy after reset want 0", seen); end
      issue(4'd8, 32'd1, 32'd2);
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (done !== 1'b1 || result !== e.res || hi !== 32'd0 || lo !== 32'd0)
         begin errors++; $display("FAIL add_after_reset: done=%b res=%h hi=%h lo=%h want done=1 res=%h hi=0 lo=0",
                                  done, result, hi, lo, e.res); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single_ops();
      test_back_to_back();
      test_muldiv();
      test_busy_ignore();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Execute-stage ALU. Consumes the 4-bit operation code from the ALU controller and two 32-bit operands from the register-read/immediate mux.
- Single-cycle ops return a registered result one edge after start.
- MULT and DIV run iteratively (32 iterations) and write the HI/LO registers.
- The pipeline stalls on busy; the writeback mux takes result/hi/lo on done.

Parameters:
- WIDTH, 32, operand/result width (HI/LO each WIDTH; shift amount uses $clog2(WIDTH) LSBs)
- ITER, WIDTH, number of mult/div iterations (fixed equal to WIDTH; not independently tunable)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  operation request, sampled on rising edge while not busy
- alu_operation  input  4  0 NOP, 1 XOR, 2 OR, 3 AND, 4 NOR, 5 SLL, 6 SRL, 7 SLT, 8 ADD, 9 ADDU, 10 SUB, 11 SUBU, 12 MULT, 13 DIV, 14-15 reserved (treated as NOP)
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt or sign-extended immediate)
- result  output  WIDTH  registered result of the last single-cycle op
- zero  output  1  result == 0 (registered with result)
- overflow  output  1  signed overflow flag (see Optional Feature)
- hi  output  WIDTH  MULT high word / DIV remainder
- lo  output  WIDTH  MULT low word / DIV quotient
- busy  output  1  mult/div in progress
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, any time, including mid-iteration): state=IDLE; result, hi, lo, zero, overflow, busy, done all 0; iteration counter 0; partial products discarded.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + start at edge N with a single-cycle op:
  - result registered at edge N; done=1 for the following cycle; state stays IDLE.
  - Back-to-back starts are allowed every cycle.
- Single-cycle op semantics:
  - XOR/OR/AND/NOR: bitwise.
  - SLL: b << a[4:0]. SRL: logical b >> a[4:0].
  - SLT: signed a<b gives 1, else 0.
  - ADD/ADDU: a+b, mod 2^32. SUB/SUBU: a-b, mod 2^32.
  - NOP/reserved: result=0, done still pulses.
- zero is computed from the new result and updated with it.
- hi/lo are not touched by single-cycle ops.
- IDLE + start with MULT/DIV at edge N:
  - Latch |a| and |b| plus both operand signs; counter=0; busy=1; go to MUL or DIV.
- MUL: unsigned shift-add, one multiplier bit per edge, 32 edges (N+1..N+32).
- DIV: restoring division, one quotient bit per edge, 32 edges.
- After the 32nd iteration: go to FIX. At edge N+33:
  - Apply signs: product negated if signs differ; quotient negated if signs differ; remainder takes the sign of a.
  - Write hi/lo; busy=0; done=1 for one cycle; state=IDLE.
  - Total: done visible 33 cycles after the start edge.
- result, zero and overflow are unchanged by MULT/DIV.
- start while busy is ignored (no queueing); operand changes while busy have no effect.
- Divide by zero:
  - Completes in normal latency with lo=all ones and hi=a.
  - No exception output.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps).
- MULT 0x80000000 * 0x80000000: hi=0x40000000, lo=0.
- done and start may coincide in the FIX cycle. The new start is accepted at the edge after busy falls, i.e. when the FSM is in IDLE; a start asserted while busy is high is dropped.

Optional Feature:
- Macro ALU_OVF_DETECT_EN.
- Defined: overflow registered with result.
  - ADD: set when both operand signs are equal and the result sign differs.
  - SUB: set when the operand signs differ and the result sign differs from a.
  - 0 for all other ops, including ADDU/SUBU.
  - result is still written on overflow.
- Undefined: overflow tied to 0, and no comparison logic is generated.

Test Plan:
- ADD a=0x7FFFFFFF, b=1, start one cycle -> result=0x80000000, done pulses one cycle, overflow=1 with macro / 0 without; ADDU same operands -> overflow=0.
- SUB a=5, b=5 -> result=0, zero=1; SLT a=0xFFFFFFFF, b=1 -> result=1; SLL a=4, b=0x1 -> result=0x10; SRL a=31, b=0x80000000 -> result=1.
- MULT a=0xFFFFFFFD (-3), b=7 -> busy for 33 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB, done one cycle; result unchanged.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=9, b=0 -> lo=0xFFFFFFFF, hi=9.
- Start MULT, hold start high and toggle a/b during busy -> single done, hi/lo reflect the original operands; assert rst at iteration 10 -> all outputs 0 immediately, no done; a fresh ADD afterwards works.
- Back-to-back XOR/OR/AND/NOR starts on consecutive cycles with a=0xF0F0F0F0, b=0xFF00FF00 -> results 0x0FF00FF0, 0xFFF0FFF0, 0xF000F000, 0x000F000F on successive cycles, done high continuously.
